// File: rtl/sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package sub_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the nibble counter; a single-nibble build still needs one bit.
  function automatic int cnt_w(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/sub_nib4.sv
// Combinational 4-bit subtract stage: {b_out, d} = a - b - b_in.
module sub_nib4
  import sub_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             b_in,
  output logic [NIB_W-1:0] d,
  output logic             b_out
);

  logic carry;

  // Two's-complement subtract: a + ~b + ~b_in; a missing carry means a borrow.
  assign {carry, d} = {1'b0, a} + {1'b0, ~b} + {{NIB_W{1'b0}}, ~b_in};
  assign b_out      = ~carry;

endmodule

// File: rtl/sub_serial_nib.sv
// Nibble-serial subtractor A - B - i_Borrow, LS nibble first, valid/ready on both sides.
// Optional signed-overflow output enabled with `define SUB_OVF_EN.
module sub_serial_nib
  import sub_pkg::*;
#(
  parameter int NIBBLES = 2
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_Valid,
  output logic                     o_Ready,
  input  logic [NIB_W*NIBBLES-1:0] i_bit1,
  input  logic [NIB_W*NIBBLES-1:0] i_bit2,
  input  logic                     i_Borrow,
  output logic                     o_Valid,
  input  logic                     i_Ready,
  output logic [NIB_W*NIBBLES-1:0] o_Resta,
  output logic                     o_Borrow
`ifdef SUB_OVF_EN
  ,
  output logic                     o_Overflow
`endif
);

  localparam int W  = NIB_W * NIBBLES;
  localparam int CW = cnt_w(NIBBLES);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    a_q, b_q, resta_q;
  logic            bin_q, borrow_q, ready_q, valid_q;
  logic            accept, last;
  logic [NIB_W-1:0] a_nib, b_nib, d_nib;
  logic            b_out;

  assign accept = i_Valid && ready_q;
  assign last   = (cnt_q == CW'(NIBBLES - 1));
  assign a_nib  = a_q[cnt_q*NIB_W +: NIB_W];
  assign b_nib  = b_q[cnt_q*NIB_W +: NIB_W];

  sub_nib4 u_stage (
    .a     (a_nib),
    .b     (b_nib),
    .b_in  (bin_q),
    .d     (d_nib),
    .b_out (b_out)
  );

  // NOTE: next-state is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)  state_d = CALC;
      CALC:    if (last)    state_d = DONE;
      DONE:    if (i_Ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake flags are registered from the next state so they line up with it.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      bin_q    <= 1'b0;
      resta_q  <= '0;
      borrow_q <= 1'b0;
    end else begin
      ready_q <= (state_d == IDLE);
      valid_q <= (state_d == DONE);
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q   <= i_bit1;
            b_q   <= i_bit2;
            bin_q <= i_Borrow;
            cnt_q <= '0;
          end
        end
        CALC: begin
          resta_q[cnt_q*NIB_W +: NIB_W] <= d_nib;
          bin_q <= b_out;
          if (last) begin
            borrow_q <= b_out;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SUB_OVF_EN
  logic ovf_q;

  // Borrow into the MSB is recovered from its sum bit: d3 = a3 ^ b3 ^ borrow_in3.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      ovf_q <= 1'b0;
    end else if (state_q == CALC && last) begin
      ovf_q <= d_nib[NIB_W-1] ^ a_nib[NIB_W-1] ^ b_nib[NIB_W-1] ^ b_out;
    end
  end

  assign o_Overflow = ovf_q;
`endif

  assign o_Ready  = ready_q;
  assign o_Valid  = valid_q;
  assign o_Resta  = resta_q;
  assign o_Borrow = borrow_q;

endmodule

// File: tb/tb_sub_serial_nib.sv
// Self-checking bench for sub_serial_nib: directed vectors on NIBBLES=2, random sweep on 1/2/4.
module tb_sub_serial_nib;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  vld_in  = '0;
  logic [2:0]  rdy_in  = '0;
  logic [2:0]  rdy_out, vld_out, bout;
  logic [2:0]  bin     = '0;
  logic [15:0] a_in [3];
  logic [15:0] b_in [3];
  logic [15:0] res  [3];
`ifdef SUB_OVF_EN
  logic [2:0]  ovf;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int N = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    localparam int W = 4 * N;
    logic [W-1:0] res_l;
`ifdef SUB_OVF_EN
    logic ovf_l;
    assign ovf[g] = ovf_l;
`endif
    sub_serial_nib #(.NIBBLES(N)) dut (
      .i_Clk     (clk),
      .i_Reset   (rst),
      .i_Valid   (vld_in[g]),
      .o_Ready   (rdy_out[g]),
      .i_bit1    (a_in[g][W-1:0]),
      .i_bit2    (b_in[g][W-1:0]),
      .i_Borrow  (bin[g]),
      .o_Valid   (vld_out[g]),
      .i_Ready   (rdy_in[g]),
      .o_Resta   (res_l),
      .o_Borrow  (bout[g])
`ifdef SUB_OVF_EN
      ,
      .o_Overflow(ovf_l)
`endif
    );
    assign res[g] = 16'(res_l);
  end

  function automatic int nibs(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : 4;
  endfunction

  // Reference: plain integer arithmetic on the operand values.
  function automatic void ref_sub(input int n, input logic [15:0] av, input logic [15:0] bv,
                                  input logic bi, output logic [15:0] r, output logic bo,
                                  output logic ov);
    int w, mask, diff, sa, sb, sd;
    w    = 4 * n;
    mask = (1 << w) - 1;
    diff = int'(av) - int'(bv) - int'(bi);
    bo   = (diff < 0);
    r    = 16'(diff & mask);
    sa   = av[w-1] ? int'(av) - (1 << w) : int'(av);
    sb   = bv[w-1] ? int'(bv) - (1 << w) : int'(bv);
    sd   = sa - sb - int'(bi);
    ov   = (sd < -(1 << (w - 1))) || (sd > (1 << (w - 1)) - 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic start_op(input int g, input logic [15:0] av, input logic [15:0] bv, input logic bi);
    int n = 0;
    while (!rdy_out[g] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", {31'd0, rdy_out[g]}, 32'd1);
    a_in[g]   = av;
    b_in[g]   = bv;
    bin[g]    = bi;
    vld_in[g] = 1'b1;
    @(negedge clk);
    vld_in[g] = 1'b0;
  endtask

  task automatic wait_valid(input int g, output int lat);
    lat = 0;
    while (!vld_out[g] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result(input int g);
    rdy_in[g] = 1'b1;
    @(negedge clk);
    rdy_in[g] = 1'b0;
    check("valid_drop", {31'd0, vld_out[g]}, 32'd0);
    check("ready_back", {31'd0, rdy_out[g]}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bi;
    logic [15:0] exp_r;
    logic        exp_bo;
  } vec_t;

  vec_t vecs [8];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    logic [15:0] er, held_r;
    logic        ebo, eov, held_b;

    for (int g = 0; g < 3; g++) begin
      a_in[g] = '0;
      b_in[g] = '0;
    end

    vecs[0] = '{16'h5A, 16'h3C, 1'b0, 16'h1E, 1'b0};
    vecs[1] = '{16'h10, 16'h0F, 1'b1, 16'h00, 1'b0};
    vecs[2] = '{16'h00, 16'h01, 1'b0, 16'hFF, 1'b1};
    vecs[3] = '{16'hFF, 16'hFF, 1'b1, 16'hFF, 1'b1};
    vecs[4] = '{16'hFF, 16'h00, 1'b0, 16'hFF, 1'b0};
    vecs[5] = '{16'h33, 16'h11, 1'b0, 16'h22, 1'b0};
    vecs[6] = '{16'h80, 16'h01, 1'b0, 16'h7F, 1'b0};
    vecs[7] = '{16'h00, 16'h00, 1'b1, 16'hFF, 1'b1};

    // Reset state and registered ready rising one edge after release.
    #12;
    check("rst_ready", {29'd0, rdy_out}, 32'd0);
    check("rst_valid", {29'd0, vld_out}, 32'd0);
    check("rst_resta", {16'd0, res[1]}, 32'd0);
    check("rst_borrow", {29'd0, bout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_pre_edge", {29'd0, rdy_out}, 32'd0);
    @(negedge clk);
    check("ready_post_edge", {29'd0, rdy_out}, 32'd7);

    // Directed vector table on the default-width instance.
    foreach (vecs[i]) begin
      start_op(1, vecs[i].a, vecs[i].b, vecs[i].bi);
      check("ready_low_busy", {31'd0, rdy_out[1]}, 32'd0);
      wait_valid(1, lat);
      check("latency", lat, 32'd2);
      check("vec_resta", {16'd0, res[1]}, {16'd0, vecs[i].exp_r});
      check("vec_borrow", {31'd0, bout[1]}, {31'd0, vecs[i].exp_bo});
      release_result(1);
    end

`ifdef SUB_OVF_EN
    start_op(1, 16'h80, 16'h01, 1'b0);
    wait_valid(1, lat);
    check("ovf_80_01", {31'd0, ovf[1]}, 32'd1);
    check("ovf_80_01_res", {16'd0, res[1]}, 32'h7F);
    release_result(1);
    start_op(1, 16'h05, 16'h03, 1'b0);
    wait_valid(1, lat);
    check("ovf_05_03", {31'd0, ovf[1]}, 32'd0);
    release_result(1);
`endif

    // Backpressure: result held, ready low, stray i_Valid ignored.
    start_op(1, 16'h5A, 16'h3C, 1'b0);
    wait_valid(1, lat);
    held_r = res[1];
    held_b = bout[1];
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        a_in[1]   = 16'hAA;
        b_in[1]   = 16'h11;
        vld_in[1] = 1'b1;
      end
      @(negedge clk);
      vld_in[1] = 1'b0;
      check("bp_valid", {31'd0, vld_out[1]}, 32'd1);
      check("bp_ready", {31'd0, rdy_out[1]}, 32'd0);
      check("bp_resta", {16'd0, res[1]}, 32'h1E);
      check("bp_borrow", {31'd0, bout[1]}, {31'd0, held_b});
    end
    check("bp_held_resta", {16'd0, held_r}, 32'h1E);
    release_result(1);
    @(negedge clk);
    check("bp_no_ghost_op", {31'd0, vld_out[1]}, 32'd0);

    // Reset between nibbles: outputs clear without a clock edge.
    start_op(1, 16'hFF, 16'h01, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", {29'd0, rdy_out}, 32'd0);
    check("midrst_valid", {29'd0, vld_out}, 32'd0);
    check("midrst_resta", {16'd0, res[1]}, 32'd0);
    check("midrst_borrow", {29'd0, bout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_back", {31'd0, rdy_out[1]}, 32'd1);
    check("midrst_no_result", {31'd0, vld_out[1]}, 32'd0);
    start_op(1, 16'h33, 16'h11, 1'b0);
    wait_valid(1, lat);
    check("postrst_resta", {16'd0, res[1]}, 32'h22);
    release_result(1);

    // Randomized sweep across widths with random result stalls.
    for (int i = 0; i < 1000; i++) begin
      int          g, w, stall;
      logic [15:0] av, bv;
      logic        bi;
      g     = i % 3;
      w     = 4 * nibs(g);
      av    = 16'($urandom & ((1 << w) - 1));
      bv    = 16'($urandom & ((1 << w) - 1));
      bi    = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 3);
      ref_sub(nibs(g), av, bv, bi, er, ebo, eov);
      start_op(g, av, bv, bi);
      wait_valid(g, lat);
      check("rand_latency", lat, nibs(g));
      repeat (stall) @(negedge clk);
      check("rand_result", {15'd0, bout[g], res[g]}, {15'd0, ebo, er});
`ifdef SUB_OVF_EN
      check("rand_ovf", {31'd0, ovf[g]}, {31'd0, eov});
`endif
      release_result(g);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sub_serial_nib.md
Name: sub_serial_nib

Overview:
- Multi-cycle nibble-serial subtractor; the inverse-direction companion to the combinational 8-bit adder path.
- Computes A - B - borrow_in, one 4-bit stage per clock, least-significant nibble first, reusing a single 4-bit subtract stage.
- Operands arrive on a valid/ready input handshake; the result leaves on a valid/ready output handshake.
- Sits beside the adder in the arithmetic datapath, for area-constrained subtraction.

Parameters:
- NIBBLES, 2, number of 4-bit nibbles; operand width W = 4*NIBBLES (default 8 bits). Legal range 1..8.

Ports:
- i_Clk  input  1  system clock, rising edge
- i_Reset  input  1  asynchronous, active-high reset
- i_Valid  input  1  operands valid
- o_Ready  output  1  block can accept operands
- i_bit1  input  W  minuend A, unsigned
- i_bit2  input  W  subtrahend B, unsigned
- i_Borrow  input  1  borrow-in
- o_Valid  output  1  result valid
- i_Ready  input  1  downstream accepts result
- o_Resta  output  W  difference (A - B - i_Borrow) mod 2^W
- o_Borrow  output  1  borrow-out
- o_Overflow  output  1  signed overflow (only with SUB_OVF_EN)

Behaviour:
- Clock and reset: one clock, i_Clk. Reset is asynchronous and active-high on i_Reset; the polarity and synchronicity are fixed.
- Reset values: state IDLE, o_Ready=0, o_Valid=0, o_Resta=0, o_Borrow=0, o_Overflow=0, nibble counter=0. o_Ready is registered and rises on the first i_Clk edge after i_Reset deasserts.
- IDLE:
  - o_Ready=1.
  - Accept on edge T when i_Valid && o_Ready: latch A, B and i_Borrow; counter=0; go to CALC; o_Ready drops to 0 after edge T.
- CALC:
  - On each edge, process nibble k=counter: {b_out, d} = A[4k+3:4k] - B[4k+3:4k] - b_in.
  - b_in is the latched i_Borrow for k=0, otherwise the previous nibble's borrow.
  - Implemented as A_nib + ~B_nib + ~b_in, with b_out = ~carry.
  - Write d into o_Resta[4k+3:4k] and increment the counter.
  - After nibble NIBBLES-1: register o_Borrow = final b_out and go to DONE.
- DONE:
  - o_Valid=1. o_Resta, o_Borrow and o_Overflow stay stable until i_Ready=1.
  - On the edge with o_Valid && i_Ready: o_Valid=0, go to IDLE, o_Ready=1 after that edge.
- Latency: o_Valid goes high after edge T+NIBBLES, i.e. 2 cycles at the default width.
- Throughput: at most one operation per NIBBLES+2 cycles. There is no overlap of accept and result; i_Valid is ignored outside IDLE.
- Arithmetic: o_Borrow=1 iff A < B + i_Borrow, unsigned. Wrap-around is mod 2^W; for example 0x00-0x01 gives 0xFF with o_Borrow=1.
- o_Resta is only meaningful while o_Valid=1. Partial nibbles may be visible during CALC.
- Reset mid-operation (CALC or DONE): all state and outputs return to reset values immediately; the in-flight operation is discarded with no result.
- i_Ready held high in IDLE or CALC has no effect.

Optional Feature:
- Macro: SUB_OVF_EN.
- Defined: o_Overflow exists. It is registered at CALC exit as b_in_msb XOR b_out_msb, i.e. A and B signs differ and the result sign differs from A. It resets to 0 and is held in DONE together with o_Resta.
- Not defined: the o_Overflow port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package sub_pkg:
  - NIB_W=4
  - state enum {IDLE, CALC, DONE}
  - counter width function clog2(NIBBLES)
- Sub-module sub_nib4: combinational 4-bit subtract stage.
  - Inputs: 4-bit a, 4-bit b, 1-bit b_in.
  - Outputs: 4-bit d, 1-bit b_out.
  - Instantiated once and muxed by the nibble counter.

Test Plan:
- NIBBLES=2, A=0x5A, B=0x3C, i_Borrow=0 -> o_Resta=0x1E, o_Borrow=0; o_Valid high exactly 2 cycles after the accept edge.
- A=0x10, B=0x0F, i_Borrow=1 (inter-nibble borrow chain) -> o_Resta=0x00, o_Borrow=0. Separately, A=0x00, B=0x01, i_Borrow=0 -> o_Resta=0xFF, o_Borrow=1.
- With SUB_OVF_EN: A=0x80, B=0x01 -> o_Resta=0x7F, o_Overflow=1, o_Borrow=0. A=0x05, B=0x03 -> o_Overflow=0.
- Backpressure: hold i_Ready=0 for 5 cycles after o_Valid -> o_Resta and o_Borrow stable, o_Ready=0, and a new i_Valid pulse is ignored. Then i_Ready=1 -> o_Valid drops and o_Ready=1 on the next cycle.
- Reset mid-CALC: assert i_Reset between nibbles -> outputs zero immediately with no clock edge. After release, o_Ready=1 one edge later, and A=0x33, B=0x11 yields 0x22.
- Randomized sweep with NIBBLES=1, 2 and 4 against a reference model computing (A-B-bin) mod 2^W and borrow -> zero mismatches over 1000 transactions, each with random i_Ready stalls.
